// File: rtl/exposure_dose_ctrl_if.sv
// Purpose: groups the sequence-controller side of the exposure dose controller.
// Latency: wiring only, no storage.
// Backpressure: none; laser_on is a level-sensitive enable and clear_fault is a single-cycle request.
interface exposure_dose_ctrl_if;
   logic        laser_on;
   logic [15:0] dose_target;
   logic        clear_fault;
   logic        laser_pulse;
   logic [15:0] pulse_count;
   logic        dose_done;
   logic        dose_fault;
   logic        busy;

   // Sequence controller side
   modport master (
      output laser_on, dose_target, clear_fault,
      input  laser_pulse, pulse_count, dose_done, dose_fault, busy
   );

   // Dose controller side
   modport slave (
      input  laser_on, dose_target, clear_fault,
      output laser_pulse, pulse_count, dose_done, dose_fault, busy
   );
endinterface

// File: rtl/exposure_dose_ctrl.sv
// Purpose: fires target*PULSE_PERIOD cycles of registered laser pulses, then reports done or an interlock fault.
// Latency: every output is registered; the first pulse rises on the edge that samples laser_on=1 in IDLE.
// Backpressure: none; dropping laser_on mid-exposure aborts to a sticky fault, completion wins a same-cycle drop.
module exposure_dose_ctrl #(
   parameter int PULSE_PERIOD = 10,
   parameter int PULSE_WIDTH  = 2
) (
   input logic                 clk,
   input logic                 reset,
   exposure_dose_ctrl_if.slave ctl
);

   localparam logic [7:0] LAST_PHASE  = 8'(PULSE_PERIOD - 1);
   localparam logic [7:0] WIDTH_PHASE = 8'(PULSE_WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      FIRE,
      DONE,
      FAULT
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  phase_q, phase_d;
   logic [7:0]  phase_inc;
   logic [15:0] target_q, target_d;
   logic [15:0] count_q, count_d;
   logic        pulse_q, pulse_d;
   logic        done_q, done_d;
   logic        fault_q, fault_d;
   logic        busy_q, busy_d;

   assign ctl.laser_pulse = pulse_q;
   assign ctl.pulse_count = count_q;
   assign ctl.dose_done   = done_q;
   assign ctl.dose_fault  = fault_q;
   assign ctl.busy        = busy_q;

   // State and output registers; reset clears everything immediately so the laser drops without a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         phase_q  <= 8'd0;
         target_q <= 16'd0;
         count_q  <= 16'd0;
         pulse_q  <= 1'b0;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         target_q <= target_d;
         count_q  <= count_d;
         pulse_q  <= pulse_d;
         done_q   <= done_d;
         fault_q  <= fault_d;
         busy_q   <= busy_d;
      end
   end

   // Next-state and next-output logic; laser_pulse defaults low so it can only be high while firing.
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      target_d  = target_q;
      count_d   = count_q;
      pulse_d   = 1'b0;
      done_d    = done_q;
      fault_d   = fault_q;
      busy_d    = busy_q;
      phase_inc = (phase_q == LAST_PHASE) ? 8'd0 : phase_q + 8'd1;

      case (state_q)
         IDLE: begin
            if (ctl.laser_on) begin
               if (ctl.dose_target != 16'd0) begin
                  // The target is captured once here and ignored for the rest of the exposure.
                  state_d  = FIRE;
                  target_d = ctl.dose_target;
                  phase_d  = 8'd0;
                  pulse_d  = 1'b1;
                  count_d  = 16'd1;
                  busy_d   = 1'b1;
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  count_d = 16'd0;
               end
            end
         end

         FIRE: begin
            if ((phase_q == LAST_PHASE) && (count_q == target_q)) begin
               // Completion is checked before the interlock so a same-cycle drop still counts as done.
               state_d = DONE;
               phase_d = 8'd0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else if (!ctl.laser_on) begin
               // Abort: pulse_count keeps the number of pulses actually started.
               state_d = FAULT;
               phase_d = 8'd0;
               fault_d = 1'b1;
               busy_d  = 1'b0;
            end else begin
               phase_d = phase_inc;
               pulse_d = (phase_inc < WIDTH_PHASE);
               if (phase_inc == 8'd0) begin
                  count_d = count_q + 16'd1;
               end
            end
         end

         DONE: begin
            // Holding laser_on high keeps us here, so an exposure never re-arms without IDLE.
            if (!ctl.laser_on) begin
               state_d = IDLE;
               done_d  = 1'b0;
               count_d = 16'd0;
            end
         end

         FAULT: begin
            if (ctl.clear_fault && !ctl.laser_on) begin
               state_d = IDLE;
               fault_d = 1'b0;
               count_d = 16'd0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_exposure_dose_ctrl.sv
// Purpose: scoreboard bench for exposure_dose_ctrl covering normal, zero, abort, clear, tie and reset cases.
// Latency: expectations are pushed with the stimulus and compared 2 ns after the following rising edge.
// Backpressure: none; one expectation is queued per driven cycle.
`timescale 1ns/1ps
module tb_exposure_dose_ctrl;

   localparam int P = 10;
   localparam int W = 2;

   typedef struct packed {
      logic        pulse;
      logic [15:0] cnt;
      logic        done;
      logic        fault;
      logic        busy;
   } obs_t;

   typedef struct {
      string tag;
      obs_t  exp;
   } sb_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;
   sb_t  sb_q[$];

   exposure_dose_ctrl_if bus ();

   exposure_dose_ctrl #(
      .PULSE_PERIOD(P),
      .PULSE_WIDTH (W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .ctl  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic obs_t mk(input logic p, input int c, input logic d, input logic f, input logic b);
      obs_t e;
      e.pulse = p;
      e.cnt   = 16'(c);
      e.done  = d;
      e.fault = f;
      e.busy  = b;
      return e;
   endfunction

   // Expected outputs k edges after the exposure starts: pulse high for the first W cycles of each period.
   function automatic obs_t fire_exp(input int k);
      return mk((k % P) < W, k / P + 1, 1'b0, 1'b0, 1'b1);
   endfunction

   task automatic cyc(input string tag, input logic lo, input int tgt, input logic clr, input obs_t e);
      sb_t s;
      @(negedge clk);
      bus.laser_on    = lo;
      bus.dose_target = 16'(tgt);
      bus.clear_fault = clr;
      s.tag = tag;
      s.exp = e;
      sb_q.push_back(s);
   endtask

   task automatic chk_all(input string tag, input obs_t e);
      chk({tag, ".pulse"}, 32'(bus.laser_pulse), 32'(e.pulse));
      chk({tag, ".cnt"},   32'(bus.pulse_count), 32'(e.cnt));
      chk({tag, ".done"},  32'(bus.dose_done),   32'(e.done));
      chk({tag, ".fault"}, 32'(bus.dose_fault),  32'(e.fault));
      chk({tag, ".busy"},  32'(bus.busy),        32'(e.busy));
   endtask

   // Monitor: pop one expectation per rising edge and compare once outputs have settled.
   always @(posedge clk) begin : mon
      sb_t s;
      #2;
      if (sb_q.size() > 0) begin
         s = sb_q.pop_front();
         chk_all(s.tag, s.exp);
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin : stim
      bus.laser_on    = 1'b1;
      bus.dose_target = 16'd3;
      bus.clear_fault = 1'b0;
      reset           = 1'b1;

      // Reset held across edges with laser_on high: nothing may start.
      repeat (2) @(posedge clk);
      #2;
      chk_all("rst", mk(0, 0, 0, 0, 0));
      @(negedge clk);
      reset        = 1'b0;
      bus.laser_on = 1'b0;

      // Normal dose, target 3; dose_target changed mid-fire, clear_fault pulsed while firing.
      cyc("a_start", 1, 3, 0, fire_exp(0));
      for (int k = 1; k < 3 * P; k++) begin
         cyc("a_fire", 1, (k >= 2) ? 7 : 3, (k == 12), fire_exp(k));
      end
      cyc("a_done", 1, 7, 0, mk(0, 3, 1, 0, 0));
      cyc("a_hold", 1, 7, 1, mk(0, 3, 1, 0, 0));
      cyc("a_hold2", 1, 7, 0, mk(0, 3, 1, 0, 0));
      cyc("a_idle", 0, 7, 0, mk(0, 0, 0, 0, 0));

      // Zero target.
      cyc("b_zero", 1, 0, 0, mk(0, 0, 1, 0, 0));
      cyc("b_hold", 1, 0, 0, mk(0, 0, 1, 0, 0));
      cyc("b_idle", 0, 0, 0, mk(0, 0, 0, 0, 0));

      // Interlock abort during the third pulse, then fault clear attempts.
      cyc("c_start", 1, 5, 0, fire_exp(0));
      for (int k = 1; k <= 2 * P; k++) begin
         cyc("c_fire", 1, 5, 0, fire_exp(k));
      end
      cyc("c_abort", 0, 5, 0, mk(0, 3, 0, 1, 0));
      cyc("c_hold", 0, 5, 0, mk(0, 3, 0, 1, 0));
      cyc("c_clr_on", 1, 5, 1, mk(0, 3, 0, 1, 0));
      cyc("c_hold_on", 1, 5, 0, mk(0, 3, 0, 1, 0));
      cyc("c_clr", 0, 5, 1, mk(0, 0, 0, 0, 0));
      cyc("c_idle", 0, 5, 0, mk(0, 0, 0, 0, 0));

      // laser_on falls on the final-pulse completion cycle: done wins.
      cyc("d_start", 1, 2, 0, fire_exp(0));
      for (int k = 1; k < 2 * P; k++) begin
         cyc("d_fire", 1, 2, 0, fire_exp(k));
      end
      cyc("d_tie", 0, 2, 0, mk(0, 2, 1, 0, 0));
      cyc("d_idle", 0, 2, 0, mk(0, 0, 0, 0, 0));

      // Reset between edges while a pulse is high, released with laser_on still high.
      cyc("e_start", 1, 4, 0, fire_exp(0));
      for (int k = 1; k <= P; k++) begin
         cyc("e_fire", 1, 4, 0, fire_exp(k));
      end
      @(posedge clk);
      #3;
      chk("e_pre_pulse", 32'(bus.laser_pulse), 32'd1);
      reset = 1'b1;
      #1;
      chk_all("e_async", mk(0, 0, 0, 0, 0));
      reset = 1'b0;
      cyc("e_restart", 1, 4, 0, fire_exp(0));
      cyc("e_fire2", 1, 4, 0, fire_exp(1));
      cyc("e_abort", 0, 4, 0, mk(0, 1, 0, 1, 0));
      cyc("e_clr", 0, 4, 1, mk(0, 0, 0, 0, 0));

      @(posedge clk);
      #4;
      chk("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/exposure_dose_ctrl.md
EXPOSURE_DOSE_CTRL -- requirements
Module: exposure_dose_ctrl

Interface
REQ-001 Parameter PULSE_PERIOD, default 10, laser pulse period in clk cycles; legal range 2..255.
REQ-002 Parameter PULSE_WIDTH, default 2, pulse high time in clk cycles; legal range 1..PULSE_PERIOD-1.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 laser_on  input  1  exposure enable from the sequence controller; level-sensitive.
REQ-006 dose_target  input  16  number of pulses required for one exposure.
REQ-007 clear_fault  input  1  single-cycle request to clear a latched fault.
REQ-008 laser_pulse  output  1  registered laser trigger pulse train.
REQ-009 pulse_count  output  16  pulses emitted in the current exposure.
REQ-010 dose_done  output  1  target dose reached; the controller uses it as its step-complete input.
REQ-011 dose_fault  output  1  exposure aborted before the target was reached; sticky.
REQ-012 busy  output  1  high while in FIRE.

Function
REQ-013 The block SHALL use states IDLE, FIRE, DONE and FAULT, held in a registered state machine.
REQ-014 IDLE, laser_on=1, dose_target>0: the block SHALL latch dose_target, enter FIRE, and on that edge set phase=0, laser_pulse=1, pulse_count=1 and busy=1.
REQ-015 IDLE, laser_on=1, dose_target=0: the block SHALL enter DONE directly with dose_done=1, pulse_count=0, and emit no pulse.
REQ-016 In FIRE, phase SHALL increment each cycle and wrap from PULSE_PERIOD-1 to 0.
REQ-017 In FIRE, laser_pulse SHALL equal (next phase < PULSE_WIDTH), registered.
REQ-018 In FIRE, pulse_count SHALL increment on each edge where phase wraps to 0 and a new pulse starts.
REQ-019 When phase=PULSE_PERIOD-1 and pulse_count equals the latched target, the block SHALL enter DONE instead of wrapping, with dose_done=1, laser_pulse=0 and busy=0.
REQ-020 Total FIRE duration SHALL be exactly target*PULSE_PERIOD cycles.
REQ-021 The latched target SHALL NOT change during FIRE, regardless of dose_target.
REQ-022 In FIRE, laser_on=0 SHALL cause FAULT on the next edge, with laser_pulse=0, busy=0 and dose_fault=1.
REQ-023 On FAULT entry, pulse_count SHALL freeze at its value.
REQ-024 laser_on falling on the same cycle as the final-pulse completion condition SHALL be treated as DONE, not FAULT; dose completion takes priority.
REQ-025 DONE SHALL hold dose_done=1 and pulse_count while laser_on=1.
REQ-026 DONE with laser_on=0 SHALL return to IDLE on the next edge, with dose_done=0 and pulse_count=0.
REQ-027 FAULT SHALL hold dose_fault=1 and laser_pulse=0 until clear_fault=1 is sampled with laser_on=0.
REQ-028 Clearing a fault SHALL return the block to IDLE with dose_fault=0 and pulse_count=0.
REQ-029 clear_fault sampled with laser_on=1 SHALL be ignored.
REQ-030 clear_fault in any state other than FAULT SHALL be ignored.
REQ-031 After DONE or FAULT, a new exposure SHALL start only after a pass through IDLE, so laser_on held high never re-arms.
REQ-032 laser_pulse SHALL never be 1 outside FIRE.

Reset
REQ-033 Asserting reset SHALL immediately force state=IDLE, phase=0, latched target=0 and all outputs to 0 (laser_pulse, pulse_count, dose_done, dose_fault, busy).
REQ-034 Reset asserted mid-FIRE SHALL drop laser_pulse without waiting for a clock edge.
REQ-035 After reset is released, the block SHALL start only on a laser_on=1 sampled at a subsequent clock edge.

Verification
REQ-036 Normal dose: PERIOD=10, WIDTH=2, target=3, laser_on held high -> 3 pulses each 2 cycles high at a 10-cycle spacing; pulse_count 1,2,3; dose_done=1 exactly 30 cycles after the first pulse starts.
REQ-037 Zero target: dose_target=0, laser_on=1 -> dose_done=1 one cycle later; laser_pulse never high; pulse_count=0.
REQ-038 Interlock abort: target=5, laser_on dropped during the 3rd pulse -> laser_pulse=0 next cycle; dose_fault=1; pulse_count stays 3.
REQ-039 Fault clear: clear_fault pulsed with laser_on=1 -> no change; pulsed with laser_on=0 -> IDLE, dose_fault=0, pulse_count=0.
REQ-040 Simultaneous events: laser_on falls on the final-pulse completion cycle -> dose_done=1, dose_fault=0.
REQ-041 Reset mid-FIRE: reset asserted between edges -> laser_pulse, busy and pulse_count go to 0 asynchronously; laser_on still high after release -> new exposure starts at the next edge.
